// File: rtl/iceboard_frame_rx.sv
// ICE board serial receive front end.
// Turns 8N1 UART bytes into checksum-verified SYNC/LEN/PAYLOAD/CHK frames.
module iceboard_frame_rx #(
   parameter int          CLKS_PER_BIT = 434,
   parameter logic [7:0]  SYNC_BYTE    = 8'hAA,
   parameter int          MAX_LEN      = 32,
   parameter int          ADDR_W       = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   output logic              frame_valid,
   output logic [7:0]        frame_len,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   input  logic              frame_ack,
   output logic              byte_strobe,
   output logic [15:0]       err_framing,
   output logic [15:0]       err_checksum,
   output logic [15:0]       err_overrun
);

   localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [7:0]  LEN_MAX  = 8'(MAX_LEN);

   typedef enum logic [1:0] {
      U_IDLE, U_START, U_DATA, U_STOP
   } ustate_t;

   typedef enum logic [1:0] {
      F_HUNT, F_LEN, F_DATA, F_CHK
   } fstate_t;

   ustate_t     ustate;
   fstate_t     fstate;
   logic        rx_s1, rx_s2, rx_d;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;
   logic [7:0]  byte_data;
   logic        stop_err;

   logic [7:0]  len;
   logic [7:0]  chk;
   logic [7:0]  wr_ptr;
   logic        blocked;
   logic        buf_we;

   logic [7:0]  mem [2**ADDR_W];

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         rx_s1       <= 1'b1;
         rx_s2       <= 1'b1;
         rx_d        <= 1'b1;
         ustate      <= U_IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         byte_data   <= '0;
         byte_strobe <= 1'b0;
         stop_err    <= 1'b0;
      end else begin
         rx_s1       <= rx;
         rx_s2       <= rx_s1;
         rx_d        <= rx_s2;
         byte_strobe <= 1'b0;
         stop_err    <= 1'b0;
         case (ustate)
            U_IDLE: begin
               if (rx_d && !rx_s2) begin
                  ustate  <= U_START;
                  cnt     <= '0;
                  bit_cnt <= '0;
               end
            end
            U_START: begin
               if (cnt == HALF_END) begin
                  cnt    <= '0;
                  ustate <= rx_s2 ? U_IDLE : U_DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            U_DATA: begin
               if (cnt == BIT_END) begin
                  cnt     <= '0;
                  shreg   <= {rx_s2, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) ustate <= U_STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            U_STOP: begin
               if (cnt == BIT_END) begin
                  cnt    <= '0;
                  ustate <= U_IDLE;
                  if (rx_s2) begin
                     byte_strobe <= 1'b1;
                     byte_data   <= shreg;
                  end else begin
                     stop_err <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: ustate <= U_IDLE;
         endcase
      end
   end

   // A frame arriving while one is held is parsed but never written.
   assign buf_we = byte_strobe && (fstate == F_DATA) && !blocked && !reset;

   always_ff @(posedge clock) begin
      if (buf_we) mem[wr_ptr[ADDR_W-1:0]] <= byte_data;
   end

   always_ff @(posedge clock) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fstate       <= F_HUNT;
         len          <= '0;
         chk          <= '0;
         wr_ptr       <= '0;
         blocked      <= 1'b0;
         frame_valid  <= 1'b0;
         frame_len    <= '0;
         err_framing  <= '0;
         err_checksum <= '0;
         err_overrun  <= '0;
      end else begin
         if (frame_ack && frame_valid) frame_valid <= 1'b0;
         if (stop_err) begin
            err_framing <= sat_inc(err_framing);
            fstate      <= F_HUNT;
         end else if (byte_strobe) begin
            case (fstate)
               F_HUNT: begin
                  if (byte_data == SYNC_BYTE) fstate <= F_LEN;
               end
               F_LEN: begin
                  if (byte_data == 8'd0 || byte_data > LEN_MAX) begin
                     err_checksum <= sat_inc(err_checksum);
                     fstate       <= F_HUNT;
                  end else begin
                     len     <= byte_data;
                     chk     <= byte_data;
                     wr_ptr  <= '0;
                     blocked <= frame_valid;
                     fstate  <= F_DATA;
                  end
               end
               F_DATA: begin
                  chk    <= chk ^ byte_data;
                  wr_ptr <= wr_ptr + 8'd1;
                  if (wr_ptr == len - 8'd1) fstate <= F_CHK;
               end
               F_CHK: begin
                  fstate <= F_HUNT;
                  if (byte_data != chk) begin
                     err_checksum <= sat_inc(err_checksum);
                  end else if (blocked || frame_valid) begin
                     err_overrun <= sat_inc(err_overrun);
                  end else begin
                     frame_valid <= 1'b1;
                     frame_len   <= len;
                  end
               end
               default: fstate <= F_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iceboard_frame_rx.sv
// Directed bench for iceboard_frame_rx at 16 clocks per UART bit.
// Drives framed byte streams on rx and checks frames, reads and counters.
module tb_iceboard_frame_rx;

   localparam int CPB = 16;

   logic        clock;
   logic        reset;
   logic        rx;
   logic        frame_valid;
   logic [7:0]  frame_len;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        frame_ack;
   logic        byte_strobe;
   logic [15:0] err_framing;
   logic [15:0] err_checksum;
   logic [15:0] err_overrun;

   int n_checks = 0;
   int n_errors = 0;
   int n_strobe = 0;
   int strobe_before;

   iceboard_frame_rx #(
      .CLKS_PER_BIT(CPB),
      .SYNC_BYTE   (8'hAA),
      .MAX_LEN     (32),
      .ADDR_W      (5)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx          (rx),
      .frame_valid (frame_valid),
      .frame_len   (frame_len),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .frame_ack   (frame_ack),
      .byte_strobe (byte_strobe),
      .err_framing (err_framing),
      .err_checksum(err_checksum),
      .err_overrun (err_overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) if (byte_strobe) n_strobe <= n_strobe + 1;

   task automatic check(input string tag, input logic [15:0] got,
                        input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx = stop;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
   endtask

   task automatic read_check(input string tag, input logic [4:0] a,
                             input logic [7:0] exp);
      rd_addr = a;
      @(negedge clock);
      check(tag, {8'h00, rd_data}, {8'h00, exp});
   endtask

   task automatic ack_frame();
      frame_ack = 1'b1;
      @(negedge clock);
      frame_ack = 1'b0;
      check("ack_clears", {15'd0, frame_valid}, 16'd0);
   endtask

   initial begin
      reset     = 1'b1;
      rx        = 1'b1;
      rd_addr   = '0;
      frame_ack = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      check("rst_valid", {15'd0, frame_valid}, 16'd0);
      check("rst_len", {8'd0, frame_len}, 16'd0);
      check("rst_rd", {8'd0, rd_data}, 16'd0);
      check("rst_strobe", {15'd0, byte_strobe}, 16'd0);
      check("rst_efr", err_framing, 16'd0);
      check("rst_eck", err_checksum, 16'd0);
      check("rst_eov", err_overrun, 16'd0);

      // clean frame
      send_byte(8'hAA, 1); send_byte(8'h03, 1);
      send_byte(8'h11, 1); send_byte(8'h22, 1);
      send_byte(8'h33, 1); send_byte(8'h03, 1);
      repeat (4) @(negedge clock);
      check("clean_valid", {15'd0, frame_valid}, 16'd1);
      check("clean_len", {8'd0, frame_len}, 16'd3);
      check("clean_strobes", 16'(n_strobe), 16'd6);
      read_check("clean_rd0", 5'd0, 8'h11);
      read_check("clean_rd1", 5'd1, 8'h22);
      read_check("clean_rd2", 5'd2, 8'h33);
      ack_frame();

      // bad checksum, then a good frame
      send_byte(8'hAA, 1); send_byte(8'h02, 1);
      send_byte(8'h10, 1); send_byte(8'h20, 1);
      send_byte(8'h00, 1);
      repeat (4) @(negedge clock);
      check("badck_valid", {15'd0, frame_valid}, 16'd0);
      check("badck_cnt", err_checksum, 16'd1);
      send_byte(8'hAA, 1); send_byte(8'h02, 1);
      send_byte(8'h10, 1); send_byte(8'h20, 1);
      send_byte(8'h32, 1);
      repeat (4) @(negedge clock);
      check("good2_valid", {15'd0, frame_valid}, 16'd1);
      check("good2_len", {8'd0, frame_len}, 16'd2);
      read_check("good2_rd1", 5'd1, 8'h20);
      ack_frame();

      // framing error and short glitch
      strobe_before = n_strobe;
      send_byte(8'h55, 0);
      repeat (40) @(negedge clock);
      check("frm_cnt", err_framing, 16'd1);
      check("frm_nostrobe", 16'(n_strobe), 16'(strobe_before));
      rx = 1'b0;
      repeat (2) @(negedge clock);
      rx = 1'b1;
      repeat (40) @(negedge clock);
      check("glitch_efr", err_framing, 16'd1);
      check("glitch_eck", err_checksum, 16'd1);
      check("glitch_nostrobe", 16'(n_strobe), 16'(strobe_before));

      // overrun: second frame while first still held
      send_byte(8'hAA, 1); send_byte(8'h01, 1);
      send_byte(8'h77, 1); send_byte(8'h76, 1);
      repeat (4) @(negedge clock);
      check("ov_first_valid", {15'd0, frame_valid}, 16'd1);
      send_byte(8'hAA, 1); send_byte(8'h01, 1);
      send_byte(8'h5A, 1); send_byte(8'h5B, 1);
      repeat (4) @(negedge clock);
      check("ov_cnt", err_overrun, 16'd1);
      check("ov_valid", {15'd0, frame_valid}, 16'd1);
      check("ov_len", {8'd0, frame_len}, 16'd1);
      read_check("ov_buf0", 5'd0, 8'h77);
      ack_frame();

      // length bounds
      send_byte(8'hAA, 1); send_byte(8'h00, 1);
      repeat (4) @(negedge clock);
      check("len0_eck", err_checksum, 16'd2);
      send_byte(8'hAA, 1); send_byte(8'h21, 1);
      repeat (4) @(negedge clock);
      check("len33_eck", err_checksum, 16'd3);
      // payload 1..32, XOR of 1..32 is 0x20, checksum 0x20^0x20 = 0
      send_byte(8'hAA, 1); send_byte(8'h20, 1);
      for (int i = 1; i <= 32; i++) send_byte(8'(i), 1);
      send_byte(8'h00, 1);
      repeat (4) @(negedge clock);
      check("len32_valid", {15'd0, frame_valid}, 16'd1);
      check("len32_len", {8'd0, frame_len}, 16'd32);
      check("len32_eck", err_checksum, 16'd3);
      read_check("len32_rd0", 5'd0, 8'h01);
      read_check("len32_rd31", 5'd31, 8'h20);
      ack_frame();

      // reset in the middle of a frame
      send_byte(8'hAA, 1); send_byte(8'h04, 1); send_byte(8'h11, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("mid_rst_eck", err_checksum, 16'd0);
      check("mid_rst_efr", err_framing, 16'd0);
      check("mid_rst_eov", err_overrun, 16'd0);
      check("mid_rst_len", {8'd0, frame_len}, 16'd0);
      check("mid_rst_rd", {8'd0, rd_data}, 16'd0);
      repeat (4) @(negedge clock);
      send_byte(8'hAA, 1); send_byte(8'h01, 1);
      send_byte(8'h42, 1); send_byte(8'h43, 1);
      repeat (4) @(negedge clock);
      check("post_rst_valid", {15'd0, frame_valid}, 16'd1);
      check("post_rst_len", {8'd0, frame_len}, 16'd1);
      check("post_rst_eck", err_checksum, 16'd0);
      read_check("post_rst_rd0", 5'd0, 8'h42);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
